// File: rtl/norm1_sqsum_window.sv
// Cross-channel sum-of-squares window for the norm1 LRN stage. It takes one pixel's channels in order
// and emits, for each channel, the zero-padded window sum of squares together with the centre activation.
module norm1_sqsum_window #(
  parameter int unsigned DIN_WIDTH  = 16,
  parameter int unsigned DOUT_WIDTH = 39,
  parameter int unsigned NUM_CH     = 96,
  parameter int unsigned HALF_WIN   = 2
) (
  input  logic                  ap_clk,
  input  logic                  ap_rst_n,
  input  logic [DIN_WIDTH-1:0]  in_data,
  input  logic                  in_valid,
  output logic                  in_ready,
  output logic [DOUT_WIDTH-1:0] out_sum,
  output logic [DIN_WIDTH-1:0]  out_center,
  output logic                  out_last,
  output logic                  out_valid,
  input  logic                  out_ready
);

  localparam int unsigned WIN   = 2 * HALF_WIN + 1;
  localparam int unsigned SQ_W  = 2 * DIN_WIDTH;
  localparam int unsigned CNT_W = $clog2(NUM_CH);

  localparam logic [CNT_W-1:0] HALF_LAST = CNT_W'(HALF_WIN - 1);
  localparam logic [CNT_W-1:0] CH_LAST   = CNT_W'(NUM_CH - 1);

  typedef enum logic [1:0] {
    FILL  = 2'd0,
    RUN   = 2'd1,
    DRAIN = 2'd2
  } state_e;

  state_e                         state_q,      state_d;
  logic [CNT_W-1:0]               cnt_q,        cnt_d;
  logic [WIN-1:0][SQ_W-1:0]       sq_sr_q,      sq_sr_d;
  logic [HALF_WIN:0][DIN_WIDTH-1:0] act_sr_q,   act_sr_d;
  logic [DOUT_WIDTH-1:0]          sum_q,        sum_d;
  logic [DOUT_WIDTH-1:0]          out_sum_q,    out_sum_d;
  logic [DIN_WIDTH-1:0]           out_center_q, out_center_d;
  logic                           out_last_q,   out_last_d;
  logic                           out_valid_q,  out_valid_d;

  logic [SQ_W-1:0]      sq_in;
  logic [SQ_W-1:0]      shift_sq;
  logic [DIN_WIDTH-1:0] shift_act;
  logic                 slot_free;
  logic                 shift_en;
  logic                 load_en;
  logic                 last_en;
  logic                 clear_en;

  always_comb begin
    sq_in     = SQ_W'(in_data) * SQ_W'(in_data);
    slot_free = !out_valid_q || out_ready;
  end

  // Control: decides whether the window advances, whether the output register loads,
  // and whether this is the final channel of the pixel.
  always_comb begin
    // NOTE: every signal written here gets a default first, so no path leaves one unassigned and no latch is inferred.
    state_d   = state_q;
    cnt_d     = cnt_q;
    in_ready  = 1'b0;
    shift_en  = 1'b0;
    shift_sq  = '0;
    shift_act = '0;
    load_en   = 1'b0;
    last_en   = 1'b0;
    clear_en  = 1'b0;

    unique case (state_q)
      FILL: begin
        in_ready = 1'b1;
        if (in_valid) begin
          shift_en  = 1'b1;
          shift_sq  = sq_in;
          shift_act = in_data;
          cnt_d     = cnt_q + CNT_W'(1);
          if (cnt_q == HALF_LAST) state_d = RUN;
        end
      end

      RUN: begin
        in_ready = slot_free;
        if (in_valid && slot_free) begin
          shift_en  = 1'b1;
          shift_sq  = sq_in;
          shift_act = in_data;
          load_en   = 1'b1;
          if (cnt_q == CH_LAST) begin
            cnt_d   = '0;
            state_d = DRAIN;
          end else begin
            cnt_d   = cnt_q + CNT_W'(1);
          end
        end
      end

      DRAIN: begin
        // Zero squares enter past the last channel, which gives the upper zero padding.
        if (slot_free) begin
          shift_en = 1'b1;
          load_en  = 1'b1;
          if (cnt_q == HALF_LAST) begin
            last_en  = 1'b1;
            clear_en = 1'b1;
            cnt_d    = '0;
            state_d  = FILL;
          end else begin
            cnt_d    = cnt_q + CNT_W'(1);
          end
        end
      end

      default: begin
        state_d = FILL;
        cnt_d   = '0;
      end
    endcase
  end

  // Datapath: window shift, running sum and output register.
  always_comb begin
    sq_sr_d      = sq_sr_q;
    act_sr_d     = act_sr_q;
    sum_d        = sum_q;
    out_sum_d    = out_sum_q;
    out_center_d = out_center_q;
    out_last_d   = out_last_q;
    out_valid_d  = out_valid_q;

    if (shift_en) begin
      sq_sr_d  = {sq_sr_q[WIN-2:0], shift_sq};
      act_sr_d = {act_sr_q[HALF_WIN-1:0], shift_act};
      // The leaving square was added earlier, so the difference never underflows.
      sum_d    = sum_q + DOUT_WIDTH'(shift_sq) - DOUT_WIDTH'(sq_sr_q[WIN-1]);
    end

    if (load_en) begin
      out_sum_d    = sum_d;
      out_center_d = act_sr_d[HALF_WIN];
      out_last_d   = last_en;
      out_valid_d  = 1'b1;
    end else if (out_ready) begin
      out_valid_d  = 1'b0;
    end

    // Start the next pixel from an all-zero window, which gives the lower zero padding.
    if (clear_en) begin
      sq_sr_d  = '0;
      act_sr_d = '0;
      sum_d    = '0;
    end
  end

  always_ff @(posedge ap_clk) begin
    // NOTE: the window registers are small flop arrays, not RAM, so resetting them costs nothing and drops any partial pixel.
    if (!ap_rst_n) begin
      state_q      <= FILL;
      cnt_q        <= '0;
      sq_sr_q      <= '0;
      act_sr_q     <= '0;
      sum_q        <= '0;
      out_sum_q    <= '0;
      out_center_q <= '0;
      out_last_q   <= 1'b0;
      out_valid_q  <= 1'b0;
    end else begin
      // NOTE: state updates are non-blocking, so every register samples its pre-edge value.
      state_q      <= state_d;
      cnt_q        <= cnt_d;
      sq_sr_q      <= sq_sr_d;
      act_sr_q     <= act_sr_d;
      sum_q        <= sum_d;
      out_sum_q    <= out_sum_d;
      out_center_q <= out_center_d;
      out_last_q   <= out_last_d;
      out_valid_q  <= out_valid_d;
    end
  end

  always_comb begin
    out_sum    = out_sum_q;
    out_center = out_center_q;
    out_last   = out_last_q;
    out_valid  = out_valid_q;
  end

endmodule

// File: tb/tb_norm1_sqsum_window.sv
// Self-checking bench for norm1_sqsum_window with NUM_CH=8, HALF_WIN=2. A per-pixel window model
// predicts every output, and hand-computed sum lists pin that model.
module tb_norm1_sqsum_window;

  localparam int N     = 8;
  localparam int H     = 2;
  localparam int DIN_W = 16;
  localparam int DOUT_W = 39;

  logic              clk;
  logic              rst_n;
  logic [DIN_W-1:0]  in_data;
  logic              in_valid;
  logic              in_ready;
  logic [DOUT_W-1:0] out_sum;
  logic [DIN_W-1:0]  out_center;
  logic              out_last;
  logic              out_valid;
  logic              out_ready;

  norm1_sqsum_window #(
    .DIN_WIDTH (DIN_W),
    .DOUT_WIDTH(DOUT_W),
    .NUM_CH    (N),
    .HALF_WIN  (H)
  ) dut (
    .ap_clk    (clk),
    .ap_rst_n  (rst_n),
    .in_data   (in_data),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .out_sum   (out_sum),
    .out_center(out_center),
    .out_last  (out_last),
    .out_valid (out_valid),
    .out_ready (out_ready)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic [63:0] sum;
    logic [15:0] center;
    logic        last;
  } exp_t;

  int          checks = 0;
  int          errors = 0;
  exp_t        exp_q[$];
  logic [63:0] cap_q[$];
  logic [15:0] stim_q[$];
  logic [15:0] pix [N];
  int          pix_idx = 0;
  bit          lat_mode = 0;
  bit          lat_next = 0;
  bit          hold_pending = 0;
  logic [63:0] held_sum;
  logic [15:0] held_center;
  logic        held_last;
  int          stall_cnt = 0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s: got 0x%0h, required 0x%0h", name, act, req);
    end
  endtask

  // Window sum straight from the definition: squares of channels k-H..k+H that exist.
  function automatic exp_t model(input int k);
    exp_t e;
    e.sum = '0;
    for (int c = k - H; c <= k + H; c++)
      if (c >= 0 && c < N) e.sum += 64'(pix[c]) * 64'(pix[c]);
    e.center = pix[k];
    e.last   = (k == N - 1);
    return e;
  endfunction

  // Compare process: everything is sampled on the falling edge.
  always @(negedge clk) begin
    if (rst_n !== 1'b1) begin
      exp_q.delete();
      pix_idx      = 0;
      hold_pending = 0;
      lat_next     = 0;
    end else begin
      if (lat_next) begin
        check("first_valid_latency", 64'(out_valid), 64'd1);
        lat_next = 0;
      end
      if (hold_pending) begin
        check("hold_valid",  64'(out_valid),  64'd1);
        check("hold_sum",    64'(out_sum),    held_sum);
        check("hold_center", 64'(out_center), 64'(held_center));
        check("hold_last",   64'(out_last),   64'(held_last));
      end
      hold_pending = out_valid && !out_ready;
      held_sum     = 64'(out_sum);
      held_center  = out_center;
      held_last    = out_last;

      if (out_valid && out_ready) begin
        if (exp_q.size() == 0) begin
          checks++;
          errors++;
          $display("FAIL unexpected_output: got sum 0x%0h, required no output", out_sum);
        end else begin
          exp_t e;
          e = exp_q.pop_front();
          check("out_sum",    64'(out_sum),    e.sum);
          check("out_center", 64'(out_center), 64'(e.center));
          check("out_last",   64'(out_last),   64'(e.last));
          cap_q.push_back(64'(out_sum));
        end
      end

      if (in_valid && in_ready) begin
        if (lat_mode && pix_idx == 2) begin
          check("first_valid_early", 64'(out_valid), 64'd0);
          lat_next = 1;
        end
        pix[pix_idx] = in_data;
        if (pix_idx >= H) exp_q.push_back(model(pix_idx - H));
        if (pix_idx == N - 1) begin
          for (int k = N - H; k < N; k++) exp_q.push_back(model(k));
          pix_idx = 0;
        end else begin
          pix_idx++;
        end
      end
    end
  end

  task automatic drive(input int v_pct, input int r_pct, input bit stall_mode);
    in_valid  = (stim_q.size() != 0) && ($urandom_range(99) < v_pct);
    in_data   = (stim_q.size() != 0) ? stim_q[0] : '0;
    out_ready = (stall_mode && stall_cnt < 3) ? 1'b0 : ($urandom_range(99) < r_pct);
  endtask

  // Feeds stim_q until it is drained; unless stop_when_fed, also waits for every output.
  task automatic run(input int v_pct, input int r_pct, input bit stall_mode,
                     input bit stop_when_fed, input int limit);
    int budget = 0;
    bit acc;
    bit done = 0;
    stall_cnt = 0;
    drive(v_pct, r_pct, stall_mode);
    while (!done) begin
      @(negedge clk);
      acc = in_valid && in_ready;
      if (stall_mode && out_valid && !out_ready) begin
        stall_cnt++;
        check("stall_in_ready", 64'(in_ready), 64'd0);
        check("stall_sum",      64'(out_sum),  64'd14);
      end
      @(posedge clk);
      #1;
      if (acc) void'(stim_q.pop_front());
      budget++;
      if (stop_when_fed) done = (stim_q.size() == 0);
      else               done = (stim_q.size() == 0) && (exp_q.size() == 0) && !out_valid;
      if (!done && budget >= limit) begin
        checks++;
        errors++;
        $display("FAIL timeout: ran %0d cycles, required completion within %0d", budget, limit);
        done = 1;
      end
      if (!done) drive(v_pct, r_pct, stall_mode);
    end
    in_valid  = 1'b0;
    out_ready = 1'b1;
  endtask

  task automatic check_list(input string tag, input int offset, input logic [63:0] lst [N]);
    for (int i = 0; i < N; i++)
      if (offset + i < cap_q.size())
        check($sformatf("%s_k%0d", tag, i), cap_q[offset + i], lst[i]);
  endtask

  task automatic push_ramp(input int n);
    for (int i = 1; i <= n; i++) stim_q.push_back(16'(i));
  endtask

  logic [63:0] ramp_sums [N] = '{64'd14, 64'd30, 64'd55, 64'd90, 64'd135, 64'd190, 64'd174, 64'd149};
  logic [63:0] max_sums  [N] = '{64'h2FFFA0003, 64'h3FFF80004, 64'h4FFF60005, 64'h4FFF60005,
                                 64'h4FFF60005, 64'h4FFF60005, 64'h3FFF80004, 64'h2FFFA0003};
  logic [63:0] twos_sums [N] = '{64'd12, 64'd16, 64'd20, 64'd20, 64'd20, 64'd20, 64'd16, 64'd12};

  initial begin
    rst_n     = 1'b0;
    in_valid  = 1'b0;
    in_data   = '0;
    out_ready = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    check("reset_out_valid",  64'(out_valid),  64'd0);
    check("reset_out_sum",    64'(out_sum),    64'd0);
    check("reset_out_center", 64'(out_center), 64'd0);
    check("reset_out_last",   64'(out_last),   64'd0);
    check("reset_in_ready",   64'(in_ready),   64'd1);
    rst_n = 1'b1;

    // Ramp 1..8 with the sink always ready; first output latency is pinned too.
    cap_q.delete();
    lat_mode = 1;
    push_ramp(N);
    run(100, 100, 0, 0, 200);
    lat_mode = 0;
    check("ramp_count", 64'(cap_q.size()), 64'(N));
    check_list("ramp", 0, ramp_sums);

    // Full-scale activations: largest window sum.
    cap_q.delete();
    for (int i = 0; i < N; i++) stim_q.push_back(16'hFFFF);
    run(100, 100, 0, 0, 200);
    check("max_count", 64'(cap_q.size()), 64'(N));
    check_list("max", 0, max_sums);

    // Sink stalled for the first three valid cycles.
    cap_q.delete();
    push_ramp(N);
    run(100, 100, 1, 0, 200);
    check("stall_cycles", 64'(stall_cnt), 64'd3);
    check("stall_count", 64'(cap_q.size()), 64'(N));
    check_list("stall", 0, ramp_sums);

    // Two pixels back to back; the second must not see the first.
    cap_q.delete();
    push_ramp(N);
    for (int i = 0; i < N; i++) stim_q.push_back(16'd2);
    run(100, 100, 0, 0, 300);
    check("b2b_count", 64'(cap_q.size()), 64'(2 * N));
    check_list("b2b_first", 0, ramp_sums);
    check_list("b2b_second", N, twos_sums);

    // Reset after five inputs, then a fresh pixel.
    push_ramp(5);
    run(100, 100, 0, 1, 100);
    rst_n = 1'b0;
    @(posedge clk);
    #1;
    check("midreset_out_valid", 64'(out_valid), 64'd0);
    check("midreset_out_sum",   64'(out_sum),   64'd0);
    check("midreset_in_ready",  64'(in_ready),  64'd1);
    rst_n = 1'b1;
    cap_q.delete();
    push_ramp(N);
    run(100, 100, 0, 0, 200);
    check("after_reset_count", 64'(cap_q.size()), 64'(N));
    check_list("after_reset", 0, ramp_sums);

    // Random data with random valid/ready over 20 pixels.
    cap_q.delete();
    for (int p = 0; p < 20; p++)
      for (int c = 0; c < N; c++) stim_q.push_back(16'($urandom_range(0, 65535)));
    run(70, 60, 0, 0, 5000);
    check("random_count", 64'(cap_q.size()), 64'(20 * N));

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
